cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N, default 4: number of functional-unit output buffers sharing the CDB; legal range 2..16.
REQ-002 Parameter STARVE_LIMIT, default 8: cycles a requester may wait before it is forced to top priority; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low = in reset.
REQ-005 request  input  N  bit i = buffer i holds at least one valid entry (its not_empty).
REQ-006 full  input  N  bit i = buffer i has all entries valid.
REQ-007 enable  input  1  CDB available this cycle; low = no grant issued.
REQ-008 permit  output  N  one-hot or zero; bit i = buffer i drives the CDB this cycle.
REQ-009 grant_valid  output  1  high when permit is non-zero.
REQ-010 grant_index  output  $clog2(N)  index of the granted buffer; 0 when grant_valid is low.
REQ-011 starved  output  N  debug; bit i = wait counter i has reached STARVE_LIMIT.

Function
REQ-012 permit, grant_valid and grant_index SHALL be combinational from request, full, enable and registered state, in the same cycle (zero latency).
REQ-013 permit SHALL never have more than one bit set, and SHALL only set bit i when request[i]=1.
REQ-014 Priority tiers, highest first: (a) requesting and starved; (b) requesting and full; (c) requesting. The grant SHALL come from the highest non-empty tier.
REQ-015 Within a tier, the winner SHALL be the first member found searching upward from (last_grant+1) mod N, wrapping from N-1 to 0.
REQ-016 last_grant SHALL be a register of width $clog2(N), updated to grant_index on each rising edge where grant_valid=1, and held otherwise.
REQ-017 Each requester i SHALL have a saturating wait counter, 8 bits wide, updated on each rising edge:
- request[i]=0 or permit[i]=1 -> 0;
- enable=1, request[i]=1, permit[i]=0 -> +1, saturating at STARVE_LIMIT;
- enable=0 -> hold.
REQ-018 starved[i] SHALL equal (counter i == STARVE_LIMIT).
REQ-019 enable=0 SHALL force permit=0 and grant_valid=0, and SHALL hold last_grant.
REQ-020 request=0 SHALL give permit=0 and grant_valid=0, and SHALL hold last_grant.
REQ-021 A sole requester SHALL be granted every enabled cycle, regardless of the last_grant value.
REQ-022 When several requesters are starved at once, they SHALL be served in round-robin order per REQ-015; no requester SHALL wait more than STARVE_LIMIT+N enabled cycles.

Reset
REQ-023 While reset=0: permit=0, grant_valid=0 and grant_index=0 SHALL take effect immediately, with no clock needed.
REQ-024 Reset values: last_grant=N-1, so the first search starts at index 0; all wait counters=0; starved=0.
REQ-025 An assertion of reset in mid-operation SHALL discard all pending arbitration state; the first grant after release SHALL follow REQ-024.

Verification (N=4, STARVE_LIMIT=3)
REQ-026 Reset released; request=1111, full=0000, enable=1 -> permit on successive cycles 0001, 0010, 0100, 1000, 0001.
REQ-027 request=0101, full=0100, enable=1 -> permit 0100 for 3 cycles while counter 0 goes 1, 2, 3 and starved=0001; 4th cycle permit=0001; next cycle counter 0=0 and permit=0100.
REQ-028 request=1111, enable=0 for 5 cycles, then enable=1 -> permit=0 and counters frozen while disabled; first grant then resumes at (last_grant+1).
REQ-029 request=1000 only -> permit=1000 and grant_index=3 every cycle; last_grant stays 3.
REQ-030 Granting 0010 with request=1111, reset driven low between clock edges -> permit=0 at once; after release, first permit=0001.
REQ-031 request[1] high for 2 ungranted cycles, then low for 1 cycle, then high -> counter 1 = 0 after the low cycle; requester 1 is not starved before 3 further ungranted cycles.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three-tier (starved, full, requesting) round-robin arbiter for the common data bus
module cdb_arbiter #(
  parameter int N = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         request,
  input  logic [N-1:0]         full,
  input  logic                 enable,
  output logic [N-1:0]         permit,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_index,
  output logic [N-1:0]         starved
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] last_grant;
  logic [7:0]    cnt [N];
  logic [N-1:0]  tier;
  int            idx;
  always_comb begin
    for (int i = 0; i < N; i++) starved[i] = cnt[i] == 8'(STARVE_LIMIT);
    tier = |(request & starved) ? request & starved :
           |(request & full)    ? request & full    : request;
    permit      = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // reset gates the grant so it drops immediately, without a clock
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!grant_valid && tier[idx] && enable && reset) begin
        grant_valid = 1'b1;
        permit[idx] = 1'b1;
        grant_index = IW'(idx);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IW'(N - 1);
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      if (grant_valid) last_grant <= grant_index;
      for (int i = 0; i < N; i++)
        cnt[i] <= (!request[i] || permit[i]) ? 8'd0 :
                  !enable ? cnt[i] :
                  starved[i] ? cnt[i] : cnt[i] + 8'd1;
    end
  end
endmodule
